// File: rtl/sub_parser_seq_if.sv
// Handshake and data bundle between the parse-action lookup, sub_parser_seq and the PHV writer.
// The master side drives the header/action list and the output-stream ready; the slave is the parser.
interface sub_parser_seq_if #(
   parameter int PKTS_HDR_LEN  = 1024,
   parameter int PARSE_ACT_LEN = 16,
   parameter int NUM_ACTS      = 10,
   parameter int VAL_OUT_LEN   = 48
);
   logic                              in_valid;
   logic                              in_ready;
   logic [PKTS_HDR_LEN-1:0]           pkts_hdr;
   logic [NUM_ACTS*PARSE_ACT_LEN-1:0] parse_acts;
   logic                              val_out_valid;
   logic                              val_out_ready;
   logic [VAL_OUT_LEN-1:0]            val_out;
   logic [1:0]                        val_out_type;
   logic [2:0]                        val_out_seq;
   logic                              val_out_err;
   logic                              done;

   modport master (
      output in_valid, pkts_hdr, parse_acts, val_out_ready,
      input  in_ready, val_out_valid, val_out, val_out_type, val_out_seq, val_out_err, done
   );

   modport slave (
      input  in_valid, pkts_hdr, parse_acts, val_out_ready,
      output in_ready, val_out_valid, val_out, val_out_type, val_out_seq, val_out_err, done
   );
endinterface

// File: rtl/sub_parser_seq.sv
// Sequential sub-parser: latches one header plus NUM_ACTS parse actions and walks them one per
// cycle, emitting a 2/4/6-byte container value per valid action on a valid/ready stream.
module sub_parser_seq #(
   parameter int PKTS_HDR_LEN  = 1024,
   parameter int PARSE_ACT_LEN = 16,
   parameter int NUM_ACTS      = 10,
   parameter int VAL_OUT_LEN   = 48
) (
   input logic              clk,
   input logic              aresetn,
   sub_parser_seq_if.slave  bus
);

   localparam int IW = (NUM_ACTS > 1) ? $clog2(NUM_ACTS) : 1;
   // Bit offsets reach 127*8+48, so never go narrower than 11 bits even for small headers.
   localparam int AW = ($clog2(PKTS_HDR_LEN) + 1 > 11) ? $clog2(PKTS_HDR_LEN) + 1 : 11;

   typedef enum logic {IDLE, RUN} state_t;

   state_t                            state;
   logic [IW-1:0]                     idx;
   logic [PKTS_HDR_LEN-1:0]           hdr_q;
   logic [NUM_ACTS*PARSE_ACT_LEN-1:0] acts_q;

   logic                   out_valid;
   logic [VAL_OUT_LEN-1:0] out_val;
   logic [1:0]             out_type;
   logic [2:0]             out_seq;
   logic                   out_err;
   logic                   out_done;

   int                     base;
   logic                   act_valid;
   logic [2:0]             act_seq;
   logic [1:0]             act_type;
   logic [6:0]             act_off;
   logic [AW-1:0]          bit_off;
   logic [AW-1:0]          width_bits;
   logic [AW-1:0]          end_bit;
   logic [47:0]            raw;
   logic [47:0]            ext;
   logic                   act_err;
   logic                   slot_free;

   always_comb begin
      base       = int'(idx) * PARSE_ACT_LEN;
      act_valid  = acts_q[base];
      act_seq    = acts_q[base + 1 +: 3];
      act_type   = acts_q[base + 4 +: 2];
      act_off    = acts_q[base + 6 +: 7];
      bit_off    = AW'(act_off) << 3;
      raw        = 48'(hdr_q >> bit_off);
      width_bits = AW'(48);
      ext        = raw;
      case (act_type)
         2'b01: begin
            width_bits = AW'(16);
            ext        = {32'd0, raw[15:0]};
         end
         2'b10: begin
            width_bits = AW'(32);
            ext        = {16'd0, raw[31:0]};
         end
         default: begin
            width_bits = AW'(48);
            ext        = raw;
         end
      endcase
      end_bit   = bit_off + width_bits;
      act_err   = end_bit > AW'(PKTS_HDR_LEN);
      slot_free = !out_valid || bus.val_out_ready;
   end

   // A stalled beat blocks processing entirely, so the output registers cannot move under stall.
   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state     <= IDLE;
         idx       <= '0;
         hdr_q     <= '0;
         acts_q    <= '0;
         out_valid <= 1'b0;
         out_val   <= '0;
         out_type  <= 2'b00;
         out_seq   <= 3'b000;
         out_err   <= 1'b0;
         out_done  <= 1'b0;
      end else begin
         out_done <= 1'b0;
         if (out_valid && bus.val_out_ready) begin
            out_valid <= 1'b0;
         end
         if (state == IDLE) begin
            if (bus.in_valid) begin
               hdr_q  <= bus.pkts_hdr;
               acts_q <= bus.parse_acts;
               idx    <= '0;
               state  <= RUN;
            end
         end else if (slot_free) begin
            if (act_valid && act_type != 2'b00) begin
               out_valid <= 1'b1;
               out_val   <= VAL_OUT_LEN'(act_err ? 48'd0 : ext);
               out_type  <= act_type;
               out_seq   <= act_seq;
               out_err   <= act_err;
            end
            if (idx == IW'(NUM_ACTS - 1)) begin
               out_done <= 1'b1;
               idx      <= '0;
               state    <= IDLE;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

   assign bus.in_ready      = (state == IDLE) && aresetn;
   assign bus.val_out_valid = out_valid;
   assign bus.val_out       = out_val;
   assign bus.val_out_type  = out_type;
   assign bus.val_out_seq   = out_seq;
   assign bus.val_out_err   = out_err;
   assign bus.done          = out_done;

endmodule

// File: doc/sub_parser_seq.md
# sub_parser_seq

Sequential, parametrised successor to the single-action sub-parser. It accepts one packet header plus a packed list of `NUM_ACTS` parse actions and walks the list one action per cycle. Each valid action produces one 2/4/6-byte container value on a valid/ready output stream, with an out-of-range error flag and an end-of-list pulse. It sits between the parse-action RAM lookup and the PHV container writer, and replaces the bank of parallel per-action sub-parsers.

## Interface
Parameters:
- `PKTS_HDR_LEN`, 1024: header width in bits; byte *k* is bits `[8k+7:8k]`.
- `PARSE_ACT_LEN`, 16: width of one parse action.
- `NUM_ACTS`, 10: actions per header, minimum 1.
- `VAL_OUT_LEN`, 48: output value width, minimum 48.

Ports:
- `clk`  in  1  clock, rising edge.
- `aresetn`  in  1  synchronous active-low reset.
- `in_valid`  in  1  header and action list are present.
- `in_ready`  out  1  block can accept; equals `state==IDLE && aresetn`.
- `pkts_hdr`  in  `PKTS_HDR_LEN`  packet header.
- `parse_acts`  in  `NUM_ACTS*PARSE_ACT_LEN`  action *i* is at `[i*PARSE_ACT_LEN +: PARSE_ACT_LEN]`.
- `val_out_valid`  out  1  output beat valid.
- `val_out_ready`  in  1  downstream accepts the beat.
- `val_out`  out  `VAL_OUT_LEN`  extracted value, zero-extended.
- `val_out_type`  out  2  01=2B, 10=4B, 11=6B.
- `val_out_seq`  out  3  container index within its type.
- `val_out_err`  out  1  extraction exceeded the header.
- `done`  out  1  one-cycle pulse: the last action of the list has been processed.

## Operation
- Action format:
  - `[0]` valid
  - `[3:1]` seq
  - `[5:4]` type (00 = none)
  - `[12:6]` byte offset
  - `[15:13]` reserved, ignored
- FSM states: IDLE and RUN.
  - IDLE: on `in_valid && in_ready`, latch `pkts_hdr` and `parse_acts`, set `idx=0`, go to RUN.
  - RUN: an action is processed in any cycle where the output slot is free, i.e. `!val_out_valid || val_out_ready`.
  - Processing idx where `[0]==0` or type==00: no beat is emitted. `val_out_valid` drops if the previous beat was consumed. `idx` increments.
  - Processing idx where the action is valid: load the output registers and set `val_out_valid=1`. `idx` increments.
  - Output field values: `val_out = {0, hdr[off*8 +: W]}` with W=16/32/48 per type; `val_out_type` = type; `val_out_seq` = seq.
  - Out-of-range rule: if `off*8 + W > PKTS_HDR_LEN`, then `val_out=0` and `val_out_err=1`, and the beat is still emitted. Otherwise `val_out_err=0`.
  - Processing `idx==NUM_ACTS-1`: `done=1` on the next cycle regardless of whether a beat was emitted. Go to IDLE.
- Output registers hold their values, unchanged, while `val_out_valid && !val_out_ready`. They never change under stall.
- Unused upper bits of `val_out` are always zero; stale bits are never retained.
- Offset arithmetic uses a width of at least `clog2(PKTS_HDR_LEN)+1` bits, so the range check cannot wrap.
- A new list may be accepted while the final beat of the previous list is still stalled. That beat is delivered before any beat of the new list.
- Reset at any time:
  - returns to IDLE;
  - discards the latched list, with no `done`;
  - clears all outputs.

## Timing
- Reset values: `val_out_valid=0`, `val_out=0`, `val_out_type=0`, `val_out_seq=0`, `val_out_err=0`, `done=0`, `state=IDLE`, `idx=0`.
- `in_ready=0` while `aresetn=0`.
- Latency, with capture at edge E0 and `val_out_ready=1` throughout:
  - action *i* is processed at edge E(i+1);
  - its beat is valid in cycle i+1;
  - `done` is high in cycle `NUM_ACTS`, coincident with the last action's beat if that action is valid;
  - `in_ready` is high again in cycle `NUM_ACTS`.
- Throughput: one action per cycle, so a full list takes `NUM_ACTS` cycles.
- Back-to-back lists: the best case is `NUM_ACTS+1` cycles per header.
- Backpressure: each stalled cycle delays the remaining actions by one cycle. `done` is delayed equally.
- Handshake rules:
  - `val_out_valid` never deasserts without a transfer;
  - `in_valid`/`pkts_hdr` are sampled only on the acceptance edge; the inputs may change afterwards.

## Test plan
- Reset state: hold `aresetn=0` for 3 cycles. Required: all outputs 0 and `in_ready=0`. After release, `in_ready=1` in the first cycle.
- Full list, no stall: `NUM_ACTS=10`, all actions valid, alternating 2B/4B/6B types, with header byte k = k.
  - Beats appear in cycles 1..10 in order.
  - A 2B beat at offset 5 gives `val_out=0x0605`.
  - `done` pulses in cycle 10.
- Sparse list: only actions 2 and 7 valid, the rest with `[0]=0` or type 00. Required: exactly 2 beats, in cycles 3 and 8; `done` in cycle 10.
- Out of range: `PKTS_HDR_LEN=1024`, a 6B action at offset 124. Required: `val_out=0`, `val_out_err=1`, `val_out_type=11`. A 2B action at offset 126 gives `err=0`.
- Backpressure: randomly drive `val_out_ready` low about 50% of the time.
  - Outputs are stable during stalls.
  - No beat is lost or duplicated, and beats stay in order.
  - `done` is delayed by exactly the number of stall cycles that blocked processing.
- Mid-list reset: assert reset during action 4 of 10, then send a new list. Required: no `done` for the first list, and only the new list's beats are seen.
